// File: rtl/wave_display_pkg.sv
// Shared constants, FSM states and column-entry type for the waveform display reader.
package wave_display_pkg;

  localparam int unsigned WaveW       = 300;  // samples/columns per frame
  localparam int unsigned WaveH       = 256;  // window height in rows
  localparam int unsigned AddrW       = 9;    // capture/column index width
  localparam logic [7:0]  OutrangeVal = 8'd255;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } state_e;

  // One column of the trace: visible flag plus the inclusive row span to draw.
  typedef struct packed {
    logic       vis;
    logic [7:0] lo;
    logic [7:0] hi;
  } col_entry_t;

  // Builds a column span from the current sample and its predecessor, so that
  // steps between neighbouring samples are drawn as vertical connectors.
  function automatic col_entry_t make_entry(input logic first, input logic [7:0] prev,
                                            input logic [7:0] y);
    col_entry_t e;
    e.vis = (y != OutrangeVal);
    e.lo  = y;
    e.hi  = y;
    if (!first && (prev != OutrangeVal) && (y != OutrangeVal)) begin
      e.lo = (prev < y) ? prev : y;
      e.hi = (prev < y) ? y : prev;
    end
    return e;
  endfunction

endpackage

// File: rtl/wave_display_if.sv
// Read bus between the display reader (master) and the waveform capture store (slave).
interface wave_display_if;
  import wave_display_pkg::*;

  logic [AddrW-1:0] rd_rom_addr;
  logic             lcd_data_req;
  logic [7:0]       rd_ad_data;
  logic             lcd_wr_over;

  modport master (
    output rd_rom_addr,
    output lcd_data_req,
    output lcd_wr_over,
    input  rd_ad_data
  );

  modport slave (
    input  rd_rom_addr,
    input  lcd_data_req,
    input  lcd_wr_over,
    output rd_ad_data
  );

endinterface

// File: rtl/wave_display_col_ram.sv
// Simple dual-port column buffer: one write port, one registered read port, contents not reset.
module wave_display_col_ram #(
  parameter int unsigned Depth = 300,
  parameter int unsigned Width = 17,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_waddr,
  input  logic [Width-1:0] i_wdata,
  input  logic [AddrW-1:0] i_raddr,
  output logic [Width-1:0] o_rdata
);

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rdata;

  // Write from the capture stage; registered read for the pixel pipeline.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wave_display.sv
// Per-frame capture sweep into a column span buffer plus a 2-cycle pixel hit pipeline.
module wave_display
  import wave_display_pkg::*;
#(
  parameter logic [10:0] WaveX0 = 11'd10,
  parameter logic [10:0] WaveY0 = 11'd16
) (
  input  logic                  i_lcd_clk,
  input  logic                  i_rst,
  input  logic                  i_frame_start,
  input  logic                  i_freeze,
  wave_display_if.master        cap,
  input  logic [10:0]           i_pixel_xpos,
  input  logic [10:0]           i_pixel_ypos,
  output logic                  o_wave_hit
);

  localparam logic [10:0] XLast = WaveX0 + 11'(WaveW) - 11'd1;
  localparam logic [10:0] YLast = WaveY0 + 11'(WaveH) - 11'd1;

  state_e           r_state, w_state_d;
  logic [AddrW-1:0] r_cnt, w_cnt_d;
  logic [AddrW-1:0] r_addr, w_addr_d;
  logic             r_req, w_req_d;
  logic             r_wr_over, w_wr_over_d;
  logic             r_frame_valid, w_frame_valid_d;

  // FSM and sweep-output registers.
  always_ff @(posedge i_lcd_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_req         <= 1'b0;
      r_wr_over     <= 1'b0;
      r_frame_valid <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_addr        <= w_addr_d;
      r_req         <= w_req_d;
      r_wr_over     <= w_wr_over_d;
      r_frame_valid <= w_frame_valid_d;
    end
  end

  // Next-state: sweep addresses 0..WaveW-1, one idle-request cycle, then signal completion.
  always_comb begin
    w_state_d       = r_state;
    w_cnt_d         = r_cnt;
    w_addr_d        = r_addr;
    w_req_d         = 1'b0;
    w_wr_over_d     = 1'b0;
    w_frame_valid_d = r_frame_valid;
    unique case (r_state)
      StIdle: begin
        if (i_frame_start && !i_freeze) begin
          w_state_d = StFetch;
          w_cnt_d   = '0;
        end
      end
      StFetch: begin
        w_req_d  = 1'b1;
        w_addr_d = r_cnt;
        w_cnt_d  = r_cnt + 1'b1;
        if (r_cnt == AddrW'(WaveW - 1)) begin
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        w_state_d = StDone;
      end
      StDone: begin
        w_wr_over_d     = 1'b1;
        w_frame_valid_d = 1'b1;
        w_state_d       = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign cap.rd_rom_addr  = r_addr;
  assign cap.lcd_data_req = r_req;
  assign cap.lcd_wr_over  = r_wr_over;

  // The store answers one cycle after it samples the address, so the write side trails
  // the request by one cycle; the last column lands on the edge that raises lcd_wr_over.
  logic             r_vld;
  logic [AddrW-1:0] r_vld_idx;
  logic [7:0]       r_prev;
  col_entry_t       w_wdata;

  // Capture-side alignment of request/index with returning data, and previous-sample hold.
  always_ff @(posedge i_lcd_clk) begin
    if (i_rst) begin
      r_vld     <= 1'b0;
      r_vld_idx <= '0;
      r_prev    <= OutrangeVal;
    end else begin
      r_vld     <= r_req;
      r_vld_idx <= r_addr;
      if (r_vld) begin
        r_prev <= cap.rd_ad_data;
      end
    end
  end

  assign w_wdata = make_entry(r_vld_idx == '0, r_prev, cap.rd_ad_data);

  // Display c0: window test on unsigned 11-bit coordinates; column index clamped outside.
  logic             w_in_win;
  logic [AddrW-1:0] w_col;
  logic [7:0]       w_row;
  col_entry_t       w_rdata;
  logic             r_in_win_d;
  logic [7:0]       r_row_d;
  logic             w_hit;
  logic             r_wave_hit;

  assign w_in_win = (i_pixel_xpos >= WaveX0) && (i_pixel_xpos <= XLast) &&
                    (i_pixel_ypos >= WaveY0) && (i_pixel_ypos <= YLast);
  assign w_col    = w_in_win ? AddrW'(i_pixel_xpos - WaveX0) : '0;
  assign w_row    = 8'(i_pixel_ypos - WaveY0);

  wave_display_col_ram #(
    .Depth (WaveW),
    .Width ($bits(col_entry_t)),
    .AddrW (AddrW)
  ) u_col_ram (
    .i_clk   (i_lcd_clk),
    .i_we    (r_vld),
    .i_waddr (r_vld_idx),
    .i_wdata (w_wdata),
    .i_raddr (w_col),
    .o_rdata (w_rdata)
  );

  // Display c0->c1 pipeline registers alongside the column RAM read.
  always_ff @(posedge i_lcd_clk) begin
    if (i_rst) begin
      r_in_win_d <= 1'b0;
      r_row_d    <= '0;
    end else begin
      r_in_win_d <= w_in_win;
      r_row_d    <= w_row;
    end
  end

  // Trace is only shown from a completed fetch and never while the buffer is being rewritten.
  assign w_hit = r_in_win_d && w_rdata.vis && (r_row_d >= w_rdata.lo) &&
                 (r_row_d <= w_rdata.hi) && r_frame_valid && (r_state == StIdle);

  // Display c1 -> output register.
  always_ff @(posedge i_lcd_clk) begin
    if (i_rst) begin
      r_wave_hit <= 1'b0;
    end else begin
      r_wave_hit <= w_hit;
    end
  end

  assign o_wave_hit = r_wave_hit;

endmodule
